// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared types and helpers for the UART word bridge: unpack FSM
//               state encoding, byte width constant and FIFO pointer/count
//               width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } unpack_state_t;

  // Read/write pointer width for a power-of-2 FIFO depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must be able to represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_bridge_if
// Description : Bundles the byte receive strobe, mode/flag controls, the
//               downstream word port and the transmit byte handshake of the
//               UART word bridge.
//               slave  : bridge side (consumes rx/controls, drives dout/tx).
//               master : environment side.
// Parameters  : WORD_W - packed word width, DEPTH - FIFO depth (sets the
//               fifo_cnt width).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_word_bridge_if #(
  parameter int WORD_W = 256,
  parameter int DEPTH  = 4
);
  import uart_bridge_pkg::*;

  logic [BYTE_W-1:0]             rx_data;
  logic                          rx_vld;
  logic                          loop_en;
  logic                          clr;
  logic [WORD_W-1:0]             dout;
  logic                          dout_vld;
  logic                          dout_rdy;
  logic [BYTE_W-1:0]             tx_data;
  logic                          tx_vld;
  logic                          tx_rdy;
  logic [cnt_width(DEPTH)-1:0]   fifo_cnt;
  logic                          overflow;
  logic                          timeout;

  modport slave (
    input  rx_data, rx_vld, loop_en, clr, dout_rdy, tx_rdy,
    output dout, dout_vld, tx_data, tx_vld, fifo_cnt, overflow, timeout
  );

  modport master (
    output rx_data, rx_vld, loop_en, clr, dout_rdy, tx_rdy,
    input  dout, dout_vld, tx_data, tx_vld, fifo_cnt, overflow, timeout
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_word.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_word
// Description : Single-clock WORD_W x DEPTH FIFO with show-ahead head word.
//               A push while full is accepted only if a pop happens in the
//               same cycle; otherwise the word is discarded (the caller flags
//               it). Pops while empty are ignored.
// Ports       : clk, rst_n (async active-low), push/wr_data, pop/rd_data,
//               full, empty, count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_word
  import uart_bridge_pkg::*;
#(
  parameter int WORD_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic                         pop,
  output logic [WORD_W-1:0]            rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // When full, the slot being written is the one being popped this cycle,
  // so simultaneous push+pop lands the new word as the last entry.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign rd_data = r_mem[r_rd_ptr];

  // Storage carries no reset: consumers only look at it when not empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_word_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_bridge
// Description : Packs UART rx bytes (first byte = MSB) into WORD_W-bit words,
//               buffers them in a DEPTH-entry FIFO and either presents them on
//               a valid/ready word port (loop_en=0) or replays them
//               byte-by-byte to the UART transmitter (loop_en=1).
// Ports       : sys_clk, sys_rst_n (async active-low),
//               bus (uart_word_bridge_if.slave): rx_data/rx_vld, loop_en, clr,
//               dout/dout_vld/dout_rdy, tx_data/tx_vld/tx_rdy, fifo_cnt,
//               overflow, timeout.
// Options     : `define UART_WORD_BRIDGE_TIMEOUT_EN to discard a partial word
//               after TIMEOUT_CYC idle cycles and raise the sticky timeout
//               flag; otherwise timeout is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_bridge
  import uart_bridge_pkg::*;
#(
  parameter int WORD_W      = 256,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  uart_word_bridge_if.slave   bus
);

  localparam int BYTES = WORD_W / BYTE_W;
  localparam int IDX_W = $clog2(BYTES);
  localparam int CNT_W = cnt_width(DEPTH);

  // ---------------------------------------------------------------- packer
  logic [IDX_W-1:0]  r_pack_cnt;
  logic [WORD_W-1:0] r_pack_word;
  logic              r_push;
  logic              w_last_byte;
  logic              w_tmo_hit;

  assign w_last_byte = bus.rx_vld && (r_pack_cnt == IDX_W'(BYTES-1));

  // Shifting in at the LSB leaves the first byte at the MSB once the word
  // is complete. The push is registered, so the word reaches the FIFO one
  // edge after its last byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pack_cnt  <= '0;
      r_pack_word <= '0;
      r_push      <= 1'b0;
    end else begin
      r_push <= w_last_byte;
      if (bus.rx_vld) begin
        r_pack_word <= {r_pack_word[WORD_W-BYTE_W-1:0], bus.rx_data};
        r_pack_cnt  <= w_last_byte ? '0 : r_pack_cnt + 1'b1;
      end else if (w_tmo_hit) begin
        r_pack_cnt  <= '0;
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic              w_pop;

  sync_fifo_word #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (r_push),
    .wr_data (r_pack_word),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // -------------------------------------------------------------- unpacker
  unpack_state_t     r_state;
  unpack_state_t     w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              w_load;
  logic              w_tx_acc;
  logic              w_dout_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tx_acc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.loop_en && !w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_rdy) begin
          w_tx_acc = 1'b1;
          if (r_idx == IDX_W'(BYTES-1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_shift <= w_head;
      r_idx   <= '0;
    end else if (w_tx_acc) begin
      r_shift <= {r_shift[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      r_idx   <= r_idx + 1'b1;
    end
  end

  // The word port is live only while the unpacker is parked in word mode;
  // a mode switch during SEND therefore waits for the current word to drain.
  assign w_dout_vld = (r_state == ST_IDLE) && !bus.loop_en && !w_empty;
  assign w_pop      = (w_dout_vld && bus.dout_rdy) || w_load;

  assign bus.dout     = w_empty ? '0 : w_head;
  assign bus.dout_vld = w_dout_vld;
  assign bus.tx_vld   = (r_state == ST_SEND);
  assign bus.tx_data  = r_shift[WORD_W-1 -: BYTE_W];
  assign bus.fifo_cnt = w_count;

  // ----------------------------------------------------------- sticky flags
  logic r_overflow;
  logic w_ovf_evt;

  assign w_ovf_evt = r_push && w_full && !w_pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      r_overflow <= 1'b1;
    end else if (bus.clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.overflow = r_overflow;

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_timeout;

  // A fresh byte always wins over an expiring partial word.
  assign w_tmo_hit = (r_pack_cnt != '0) && !bus.rx_vld &&
                     (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idle_cnt <= '0;
    end else if (bus.rx_vld || (r_pack_cnt == '0) || w_tmo_hit) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_tmo_hit) begin
      r_timeout <= 1'b1;
    end else if (bus.clr) begin
      r_timeout <= 1'b0;
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_timeout_cyc;

  assign w_unused_timeout_cyc = ^TIMEOUT_CYC;
  assign w_tmo_hit            = 1'b0;
  assign bus.timeout          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_word_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_bridge
// Description : Self-checking bench for uart_word_bridge (WORD_W=32, DEPTH=4).
//               Words expected on dout and bytes expected on tx are queued
//               when stimulus is driven and compared when the DUT hands them
//               over. Covers reset state, packing latency, overflow/clr,
//               full push+pop, loopback with back-pressure, mode switch,
//               partial-word timeout (or its absence) and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_bridge;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;

  uart_word_bridge_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

  uart_word_bridge #(
    .WORD_W      (WORD_W),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (100)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [7:0]        tx_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------- monitors
  logic       prev_hold = 1'b0;
  logic [7:0] prev_tx   = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_vld && bus.dout_rdy) begin
        if (exp_q.size() == 0) begin
          check("dout_unexpected", 64'(bus.dout), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("dout_word", 64'(bus.dout), 64'(exp_q.pop_front()));
        end
      end
      if (prev_hold) begin
        check("tx_hold_vld", 64'(bus.tx_vld), 64'd1);
        check("tx_hold_data", 64'(bus.tx_data), 64'(prev_tx));
      end
      if (bus.tx_vld) begin
        check("dout_vld_in_send", 64'(bus.dout_vld), 64'd0);
        if (bus.tx_rdy) begin
          if (tx_q.size() == 0) begin
            check("tx_unexpected", 64'(bus.tx_data), 64'h1FF);
          end else begin
            check("tx_byte", 64'(bus.tx_data), 64'(tx_q.pop_front()));
          end
        end
      end
      prev_hold = bus.tx_vld && !bus.tx_rdy;
      prev_tx   = bus.tx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    @(posedge clk);
    #1 bus.rx_vld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_q.size() != 0 || bus.fifo_cnt != 0 || bus.tx_vld) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(k < budget), 64'd1);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] bytes_in;
    int          gap;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[4];

  logic [31:0] ovf_words[5];

  // ------------------------------------------------------------- stimulus
  initial begin
    int k;

    vecs[0] = '{bytes_in: 32'h11223344, gap: 0, exp_word: 32'h11223344};
    vecs[1] = '{bytes_in: 32'hA55AFF00, gap: 2, exp_word: 32'hA55AFF00};
    vecs[2] = '{bytes_in: 32'h00000001, gap: 1, exp_word: 32'h00000001};
    vecs[3] = '{bytes_in: 32'hDEADBEEF, gap: 3, exp_word: 32'hDEADBEEF};

    ovf_words[0] = 32'h01020304;
    ovf_words[1] = 32'h05060708;
    ovf_words[2] = 32'h090A0B0C;
    ovf_words[3] = 32'h0D0E0F10;
    ovf_words[4] = 32'h11121314;

    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_vld   = 1'b0;
    bus.loop_en  = 1'b0;
    bus.clr      = 1'b0;
    bus.dout_rdy = 1'b1;
    bus.tx_rdy   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_dout_vld", 64'(bus.dout_vld), 64'd0);
    check("rst_tx_vld", 64'(bus.tx_vld), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_timeout", 64'(bus.timeout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word mode, table driven: push latency and single-cycle dout_vld
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp_word);
      for (int i = 0; i < 4; i++) begin
        send_byte(vecs[v].bytes_in[31-8*i -: 8]);
        if (i < 3) begin
          repeat (vecs[v].gap) @(posedge clk);
          #1;
        end
      end
      @(negedge clk);
      check("pack_lat_vld", 64'(bus.dout_vld), 64'd0);
      check("pack_lat_cnt", 64'(bus.fifo_cnt), 64'd0);
      @(negedge clk);
      check("word_vld", 64'(bus.dout_vld), 64'd1);
      check("word_dout", 64'(bus.dout), 64'(vecs[v].exp_word));
      check("word_cnt", 64'(bus.fifo_cnt), 64'd1);
      @(negedge clk);
      check("word_vld_drop", 64'(bus.dout_vld), 64'd0);
      check("word_cnt_zero", 64'(bus.fifo_cnt), 64'd0);
      @(posedge clk);
      #1;
    end

    // Overflow: 5 words into a 4-deep FIFO with no reader
    bus.dout_rdy = 1'b0;
    for (int w = 0; w < 4; w++) exp_q.push_back(ovf_words[w]);
    for (int w = 0; w < 5; w++) send_word(ovf_words[w]);
    repeat (2) @(negedge clk);
    check("ovf_cnt", 64'(bus.fifo_cnt), 64'd4);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    check("ovf_head", 64'(bus.dout), 64'(ovf_words[0]));
    pulse_clr();
    @(negedge clk);
    check("clr_flag", 64'(bus.overflow), 64'd0);
    check("clr_cnt", 64'(bus.fifo_cnt), 64'd4);
    @(posedge clk);
    #1;

    // Full FIFO: pop and push in the same cycle
    exp_q.push_back(32'hE1E2E3E4);
    send_byte(8'hE1);
    send_byte(8'hE2);
    send_byte(8'hE3);
    send_byte(8'hE4);
    bus.dout_rdy = 1'b1;
    @(posedge clk);
    #1 bus.dout_rdy = 1'b0;
    @(negedge clk);
    check("full_pp_cnt", 64'(bus.fifo_cnt), 64'd4);
    check("full_pp_ovf", 64'(bus.overflow), 64'd0);
    check("full_pp_head", 64'(bus.dout), 64'(ovf_words[1]));
    bus.dout_rdy = 1'b1;
    wait_idle("full_pp_drain", 40);
    check("full_pp_ovf_end", 64'(bus.overflow), 64'd0);

    // Loopback with tx_rdy toggling 1-0-1
    @(posedge clk);
    #1;
    bus.loop_en = 1'b1;
    bus.tx_rdy  = 1'b1;
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    tx_q.push_back(8'hCC);
    tx_q.push_back(8'hDD);
    send_word(32'hAABBCCDD);
    k = 0;
    while ((tx_q.size() != 0 || bus.tx_vld) && k < 60) begin
      @(posedge clk);
      #1 bus.tx_rdy = ~bus.tx_rdy;
      k++;
    end
    check("loop_done", 64'(k < 60), 64'd1);
    @(negedge clk);
    check("loop_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("loop_tx_idle", 64'(bus.tx_vld), 64'd0);

    // Mode switch 1 -> 0 mid-SEND with a second word queued
    @(posedge clk);
    #1;
    bus.tx_rdy = 1'b0;
    tx_q.push_back(8'h10);
    tx_q.push_back(8'h20);
    tx_q.push_back(8'h30);
    tx_q.push_back(8'h40);
    exp_q.push_back(32'h50607080);
    send_word(32'h10203040);
    send_word(32'h50607080);
    repeat (2) @(negedge clk);
    check("sw_tx_vld", 64'(bus.tx_vld), 64'd1);
    check("sw_tx_first", 64'(bus.tx_data), 64'h10);
    check("sw_cnt", 64'(bus.fifo_cnt), 64'd1);
    check("sw_dout_vld", 64'(bus.dout_vld), 64'd0);
    @(posedge clk);
    #1;
    bus.loop_en = 1'b0;
    bus.tx_rdy  = 1'b1;
    wait_idle("sw_drain", 50);

    // Partial word idle behaviour
    @(posedge clk);
    #1;
`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
    send_byte(8'h5A);
    send_byte(8'h6B);
    repeat (50) @(negedge clk);
    check("tmo_early", 64'(bus.timeout), 64'd0);
    repeat (55) @(negedge clk);
    check("tmo_set", 64'(bus.timeout), 64'd1);
    check("tmo_cnt", 64'(bus.fifo_cnt), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(32'hC1C2C3C4);
    send_word(32'hC1C2C3C4);
    wait_idle("tmo_clean_word", 20);
    check("tmo_sticky", 64'(bus.timeout), 64'd1);
    pulse_clr();
    @(negedge clk);
    check("tmo_clr", 64'(bus.timeout), 64'd0);
`else
    send_byte(8'h5A);
    send_byte(8'h6B);
    repeat (110) @(negedge clk);
    check("notmo_flag", 64'(bus.timeout), 64'd0);
    check("notmo_cnt", 64'(bus.fifo_cnt), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(32'h5A6B7C8D);
    send_byte(8'h7C);
    send_byte(8'h8D);
    wait_idle("notmo_word", 20);
`endif

    // Async reset mid-word with a word stored
    @(posedge clk);
    #1;
    bus.dout_rdy = 1'b0;
    send_word(32'h0F1E2D3C);
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (2) @(negedge clk);
    check("pre_rst_cnt", 64'(bus.fifo_cnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", 64'(bus.dout), 64'd0);
    check("arst_vld", 64'(bus.dout_vld), 64'd0);
    check("arst_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("arst_tx_vld", 64'(bus.tx_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.dout_rdy = 1'b1;
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678);
    wait_idle("post_rst_word", 20);

    check("dout_q_empty", 64'(exp_q.size()), 64'd0);
    check("tx_q_empty", 64'(tx_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
